// File: rtl/irq_cond_pkg.sv
// Shared types and constants for the interrupt conditioner.
package irq_cond_pkg;

    // Width of the pulse-length and glitch-filter down-counters.
    localparam int CNT_W  = 4;
    // Width of the post-reset warm-up counter (covers sync depth + filter length + 1).
    localparam int WARM_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } ch_state_e;

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: synchronizer, optional glitch filter
// (IRQ_COND_GLITCH_FILTER_EN), rising-edge detect, pending and overflow
// flags, and the pulse-shaping FSM.
//
//   state | meaning
//   IDLE  | no pulse in flight; a set pending flag launches PULSE next edge
//   PULSE | irq_out high, counter runs down from PULSE_LEN-1
//   GAP   | one forced low cycle; goes straight to PULSE if pending, else IDLE
module irq_channel
    import irq_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic irq_raw_i,
    input  logic irq_mask_i,
    input  logic ovf_clear_i,
    output logic irq_out_o,
    output logic pending_o,
    output logic overflow_o
);

`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    // Edge detection stays disabled until the sync chain (and filter) hold a
    // real sample, so a source already high at reset release is not an event.
    localparam int WARM_CYC = SYNC_STAGES + 1 + (FILT_ON ? FILTER_LEN : 0);
    localparam logic [WARM_W-1:0] WARM_INIT    = WARM_W'(WARM_CYC);
    localparam logic [CNT_W-1:0]  PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   cond_bit;
    logic                   prev_q;
    logic [WARM_W-1:0]      warm_q;
    logic                   seeded;
    logic                   evt;
    logic                   take;
    ch_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   ovf_q, ovf_d;

    // Metastability chain for the asynchronous source.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw_i};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] FILT_RELOAD = CNT_W'(FILTER_LEN - 1);

    logic             filt_q;
    logic [CNT_W-1:0] fcnt_q;

    // Output follows the input only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_q <= 1'b0;
            fcnt_q <= FILT_RELOAD;
        end else if (sync_bit == filt_q) begin
            fcnt_q <= FILT_RELOAD;
        end else if (fcnt_q == '0) begin
            filt_q <= sync_bit;
            fcnt_q <= FILT_RELOAD;
        end else begin
            fcnt_q <= fcnt_q - CNT_W'(1);
        end
    end

    assign cond_bit = filt_q;
`else
    assign cond_bit = sync_bit;
`endif

    // Previous-sample register plus warm-up down-counter that seeds it after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
            warm_q <= WARM_INIT;
        end else begin
            prev_q <= cond_bit;
            if (!seeded) begin
                warm_q <= warm_q - WARM_W'(1);
            end
        end
    end

    assign seeded = (warm_q == '0);
    assign evt    = seeded & cond_bit & ~prev_q & ~irq_mask_i;

    // State, pulse counter and flag registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next state; a pending event is consumed when a pulse is launched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_RELOAD;
                    take    = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (pending_q) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_RELOAD;
                    take    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending and overflow flags; a set always beats a same-cycle clear.
    // Any event that finds pending already set is flagged as overflow.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        if (take) begin
            pending_d = 1'b0;
        end
        if (evt) begin
            pending_d = 1'b1;
        end
        if (ovf_clear_i) begin
            ovf_d = 1'b0;
        end
        if (evt && pending_q) begin
            ovf_d = 1'b1;
        end
    end

    assign irq_out_o  = (state_q == PULSE);
    assign pending_o  = pending_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/irq_conditioner.sv
// Interrupt conditioner top: synchronizes reset release and instantiates one
// independent irq_channel per interrupt line. Define IRQ_COND_GLITCH_FILTER_EN
// to add a FILTER_LEN-sample glitch filter behind each synchronizer.
module irq_conditioner
    import irq_cond_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int FILTER_LEN  = 4
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic [NUM_IRQ-1:0] irq_overflow,
    input  logic [NUM_IRQ-1:0] ovf_clear
);

    logic [1:0] rst_sync_q;
    logic       rst_b;

    // Reset asserts asynchronously and releases two clocks after nreset rises.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_b = rst_sync_q[1];

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
        irq_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk_i       (clk),
            .rst_n_i     (rst_b),
            .irq_raw_i   (irq_raw[g]),
            .irq_mask_i  (irq_mask[g]),
            .ovf_clear_i (ovf_clear[g]),
            .irq_out_o   (irq_out[g]),
            .pending_o   (irq_pending[g]),
            .overflow_o  (irq_overflow[g])
        );
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// Self-checking bench for irq_conditioner: one default instance (PULSE_LEN=1)
// and one with PULSE_LEN=3, driven by the same stimulus.
module tb_irq_conditioner;

    localparam int N = 8;
`ifdef IRQ_COND_GLITCH_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 0;
`endif

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [N-1:0] irq_raw = '0;
    logic [N-1:0] irq_mask = '0;
    logic [N-1:0] ovf_clear = '0;
    logic [N-1:0] out_a, pend_a, ovf_a;
    logic [N-1:0] out_b, pend_b, ovf_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    irq_conditioner #(.NUM_IRQ(N)) dut_a (
        .clk(clk), .nreset(nreset), .irq_raw(irq_raw), .irq_mask(irq_mask),
        .irq_out(out_a), .irq_pending(pend_a), .irq_overflow(ovf_a), .ovf_clear(ovf_clear)
    );

    irq_conditioner #(.NUM_IRQ(N), .PULSE_LEN(3)) dut_b (
        .clk(clk), .nreset(nreset), .irq_raw(irq_raw), .irq_mask(irq_mask),
        .irq_out(out_b), .irq_pending(pend_b), .irq_overflow(ovf_b), .ovf_clear(ovf_clear)
    );

    typedef struct {
        int ch;
        bit mask;
        int lat;
        int w_a;
        int w_b;
        int pend;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies raw/ovf_clear patterns (bit k drives the cycle before edge k+1)
    // and compares irq_out of both instances after every edge.
    task automatic run_seq(input string name, input int ch, input logic [15:0] raw_pat,
                           input logic [15:0] clr_pat, input logic [15:0] exp_a,
                           input logic [15:0] exp_b);
        for (int k = 0; k < 16; k++) begin
            irq_raw[ch]   = raw_pat[k];
            ovf_clear[ch] = clr_pat[k];
            tick();
            check($sformatf("%s out_a k%0d", name, k + 1), int'(out_a[ch]), int'(exp_a[k]));
            check($sformatf("%s out_b k%0d", name, k + 1), int'(out_b[ch]), int'(exp_b[k]));
        end
        irq_raw[ch]   = 1'b0;
        ovf_clear[ch] = 1'b0;
    endtask

    initial begin
        int fa, fb, wa, wb, pa, pb, quiet, ch, hits;

        vecs[0] = '{ch: 3, mask: 1'b0, lat: 4 + FILT, w_a: 1, w_b: 3, pend: 1};
        vecs[1] = '{ch: 0, mask: 1'b0, lat: 4 + FILT, w_a: 1, w_b: 3, pend: 1};
        vecs[2] = '{ch: 7, mask: 1'b0, lat: 4 + FILT, w_a: 1, w_b: 3, pend: 1};
        vecs[3] = '{ch: 2, mask: 1'b1, lat: 0,        w_a: 0, w_b: 0, pend: 0};
        vecs[4] = '{ch: 5, mask: 1'b1, lat: 0,        w_a: 0, w_b: 0, pend: 0};
        vecs[5] = '{ch: 1, mask: 1'b0, lat: 4 + FILT, w_a: 1, w_b: 3, pend: 1};

        // reset state
        repeat (3) tick();
        check("rst out_a", int'(out_a), 0);
        check("rst pend_a", int'(pend_a), 0);
        check("rst ovf_a", int'(ovf_a), 0);
        check("rst out_b", int'(out_b), 0);
        check("rst pend_b", int'(pend_b), 0);
        check("rst ovf_b", int'(ovf_b), 0);
        nreset = 1'b1;
        repeat (30) tick();

        // single edges: latency, width, pending, masking, independence
        for (int i = 0; i < 6; i++) begin
            ch = vecs[i].ch;
            fa = 0; fb = 0; wa = 0; wb = 0; pa = 0; pb = 0; quiet = 0;
            irq_mask[ch] = vecs[i].mask;
            irq_raw[ch]  = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                if (k == 13) irq_mask[ch] = 1'b0;
                tick();
                if (out_a[ch]) begin wa++; if (fa == 0) fa = k; end
                if (out_b[ch]) begin wb++; if (fb == 0) fb = k; end
                if (pend_a[ch]) pa++;
                if (pend_b[ch]) pb++;
                if (((out_a | out_b | pend_a | pend_b) & ~(N'(1) << ch)) != '0) quiet++;
            end
            check($sformatf("vec%0d ch%0d lat_a", i, ch), fa, vecs[i].lat);
            check($sformatf("vec%0d ch%0d lat_b", i, ch), fb, vecs[i].lat);
            check($sformatf("vec%0d ch%0d width_a", i, ch), wa, vecs[i].w_a);
            check($sformatf("vec%0d ch%0d width_b", i, ch), wb, vecs[i].w_b);
            check($sformatf("vec%0d ch%0d pend_a", i, ch), pa, vecs[i].pend);
            check($sformatf("vec%0d ch%0d pend_b", i, ch), pb, vecs[i].pend);
            check($sformatf("vec%0d ch%0d others", i, ch), quiet, 0);
            irq_raw  = '0;
            irq_mask = '0;
            repeat (30) tick();
        end

`ifndef IRQ_COND_GLITCH_FILTER_EN
        // two edges two cycles apart: one low cycle between pulses, no overflow
        run_seq("two_edges", 0, 16'hFFFD, 16'h0000, 16'h0028, 16'h03B8);
        check("two_edges ovf_a", int'(ovf_a[0]), 0);
        check("two_edges ovf_b", int'(ovf_b[0]), 0);
        repeat (30) tick();

        // three edges: third one lost on the PULSE_LEN=3 instance
        run_seq("three_edges", 1, 16'h0015, 16'h0000, 16'h00A8, 16'h03B8);
        check("three_edges ovf_a", int'(ovf_a[1]), 0);
        check("three_edges ovf_b", int'(ovf_b[1]), 1);
        repeat (5) tick();
        check("ovf sticky", int'(ovf_b[1]), 1);
        ovf_clear[1] = 1'b1;
        tick();
        ovf_clear[1] = 1'b0;
        check("ovf cleared", int'(ovf_b[1]), 0);
        repeat (30) tick();

        // overflow set in the same cycle as ovf_clear: set wins
        run_seq("ovf_set_clr", 1, 16'h0015, 16'h007F, 16'h00A8, 16'h03B8);
        check("ovf_set_clr ovf_b", int'(ovf_b[1]), 1);
        ovf_clear = '1;
        tick();
        ovf_clear = '0;
        repeat (30) tick();

        // event coinciding with the pending consume: pending survives, extra pulse
        run_seq("set_wins", 6, 16'h0025, 16'h0000, 16'h0128, 16'h3BB8);
        ovf_clear = '1;
        tick();
        ovf_clear = '0;
        repeat (30) tick();
`else
        // glitch filter: 2-cycle glitch rejected, 6-cycle level passes at latency 8
        hits = 0;
        for (int k = 1; k <= 20; k++) begin
            irq_raw[6] = (k <= 2);
            tick();
            if (out_a[6] || out_b[6]) hits++;
        end
        check("glitch no pulse", hits, 0);
        repeat (30) tick();
        fa = 0; wa = 0;
        for (int k = 1; k <= 20; k++) begin
            irq_raw[6] = (k <= 6);
            tick();
            if (out_a[6]) begin wa++; if (fa == 0) fa = k; end
        end
        check("level lat_a", fa, 8);
        check("level width_a", wa, 1);
        irq_raw = '0;
        repeat (30) tick();
`endif

        // reset mid-pulse on the PULSE_LEN=3 instance, source held high
        irq_raw[4] = 1'b1;
        repeat (5 + FILT) tick();
        check("pre-reset out_b", int'(out_b[4]), 1);
        nreset = 1'b0;
        #1;
        check("mid-reset out_a", int'(out_a), 0);
        check("mid-reset out_b", int'(out_b), 0);
        check("mid-reset pend_b", int'(pend_b), 0);
        tick();
        nreset = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if ((out_a | out_b | pend_a | pend_b) != '0) hits++;
        end
        check("post-reset no pulse", hits, 0);
        irq_raw = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
